// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC
//
// Storage end of the CP0 read / MTC0 write path. Takes MTC0 writes from WB,
// exception and ERET events from the commit point, runs the Count/Compare
// timer and raises the registered interrupt request.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   RAddr / RData             combinational read port, pre-update, unimplemented regs read 0
//   WE, WBWAddr, WData        MTC0 write from WB
//   HwInt                     external interrupt lines, level-sensitive
//   ExcValid, ExcCode, ExcPC,
//   ExcBD, ExcBadVA           exception commit
//   Eret                      ERET commit
//   EPCOut                    current EPC (ERET return target)
//   ExcTarget                 exception vector, constant
//   IntReq                    interrupt request to pipeline (registered)

module cp0_regfile #(
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  RAddr,
    output logic [31:0] RData,
    input  logic        WE,
    input  logic [4:0]  WBWAddr,
    input  logic [31:0] WData,
    input  logic [5:0]  HwInt,
    input  logic        ExcValid,
    input  logic [4:0]  ExcCode,
    input  logic [31:0] ExcPC,
    input  logic        ExcBD,
    input  logic [31:0] ExcBadVA,
    input  logic        Eret,
    output logic [31:0] EPCOut,
    output logic [31:0] ExcTarget,
    output logic        IntReq
);

    localparam int                DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(COUNT_DIV - 1);

    localparam logic [4:0] R_BADVADDR = 5'd8;
    localparam logic [4:0] R_COUNT    = 5'd9;
    localparam logic [4:0] R_COMPARE  = 5'd11;
    localparam logic [4:0] R_STATUS   = 5'd12;
    localparam logic [4:0] R_CAUSE    = 5'd13;
    localparam logic [4:0] R_EPC      = 5'd14;

    logic [31:0]      badvaddr_q, badvaddr_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic [31:0]      epc_q, epc_d;
    logic [7:0]       im_q, im_d;
    logic             exl_q, exl_d;
    logic             ie_q, ie_d;
    logic             bd_q, bd_d;
    logic             timer_q, timer_d;   // Count==Compare latch, part of IP[7]
    logic [5:0]       hw_q, hw_d;         // registered HwInt; [5] folds into IP[7]
    logic [1:0]       ipsw_q, ipsw_d;
    logic [4:0]       exccode_q, exccode_d;
    logic             intreq_q, intreq_d;
    logic [DIV_W-1:0] div_q, div_d;

    logic [7:0] ip;
    logic       wr_count, wr_compare, wr_status, wr_cause, wr_epc;

    assign ip = {timer_q | hw_q[5], hw_q[4:0], ipsw_q};

    assign wr_count   = WE && (WBWAddr == R_COUNT);
    assign wr_compare = WE && (WBWAddr == R_COMPARE);
    assign wr_status  = WE && (WBWAddr == R_STATUS);
    assign wr_cause   = WE && (WBWAddr == R_CAUSE);
    assign wr_epc     = WE && (WBWAddr == R_EPC);

    always_comb begin
        RData = 32'h0;
        case (RAddr)
            R_BADVADDR: RData = badvaddr_q;
            R_COUNT:    RData = count_q;
            R_COMPARE:  RData = compare_q;
            R_STATUS:   RData = {16'h0, im_q, 6'h0, exl_q, ie_q};
            R_CAUSE:    RData = {bd_q, 15'h0, ip, 1'b0, exccode_q, 2'b00};
            R_EPC:      RData = epc_q;
            default:    RData = 32'h0;
        endcase
    end

    always_comb begin
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        epc_d      = epc_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        timer_d    = timer_q;
        ipsw_d     = ipsw_q;
        exccode_d  = exccode_q;
        div_d      = div_q;
        hw_d       = HwInt;
        intreq_d   = ie_q & ~exl_q & (|(im_q & ip));

        // An MTC0 load of Count restarts the divider and beats the increment.
        if (wr_count) begin
            count_d = WData;
            div_d   = '0;
        end else if (div_q == DIV_LAST) begin
            count_d = count_q + 32'd1;
            div_d   = '0;
        end else begin
            div_d = div_q + 1'b1;
        end

        if (wr_compare) begin
            compare_d = WData;
        end

        // Writing Compare acknowledges the timer and wins over a same-cycle match.
        if (wr_compare) begin
            timer_d = 1'b0;
        end else if ((count_q == compare_q) && (compare_q != 32'h0)) begin
            timer_d = 1'b1;
        end

        if (ExcValid) begin
            // Nested exception keeps the original return point.
            if (!exl_q) begin
                epc_d = ExcBD ? (ExcPC - 32'd4) : ExcPC;
                bd_d  = ExcBD;
            end
            exl_d     = 1'b1;
            exccode_d = ExcCode;
            if ((ExcCode == 5'd4) || (ExcCode == 5'd5)) begin
                badvaddr_d = ExcBadVA;
            end
        end else begin
            if (wr_status) begin
                im_d  = WData[15:8];
                exl_d = WData[1];
                ie_d  = WData[0];
            end
            if (Eret) begin
                exl_d = 1'b0;
            end
            if (wr_cause) begin
                ipsw_d = WData[9:8];
            end
            if (wr_epc) begin
                epc_d = WData;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            badvaddr_q <= 32'h0;
            count_q    <= 32'h0;
            compare_q  <= 32'h0;
            epc_q      <= 32'h0;
            im_q       <= 8'h0;
            exl_q      <= 1'b1;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            timer_q    <= 1'b0;
            hw_q       <= 6'h0;
            ipsw_q     <= 2'h0;
            exccode_q  <= 5'h0;
            intreq_q   <= 1'b0;
            div_q      <= '0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            epc_q      <= epc_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            timer_q    <= timer_d;
            hw_q       <= hw_d;
            ipsw_q     <= ipsw_d;
            exccode_q  <= exccode_d;
            intreq_q   <= intreq_d;
            div_q      <= div_d;
        end
    end

    assign EPCOut    = epc_q;
    assign ExcTarget = EXC_VECTOR;
    assign IntReq    = intreq_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// tb/tb_cp0_regfile.sv - self-checking bench for cp0_regfile

module tb_cp0_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  RAddr;
    logic [31:0] RData;
    logic        WE;
    logic [4:0]  WBWAddr;
    logic [31:0] WData;
    logic [5:0]  HwInt;
    logic        ExcValid;
    logic [4:0]  ExcCode;
    logic [31:0] ExcPC;
    logic        ExcBD;
    logic [31:0] ExcBadVA;
    logic        Eret;
    logic [31:0] EPCOut;
    logic [31:0] ExcTarget;
    logic        IntReq;

    int n_vec = 0;
    int n_err = 0;

    cp0_regfile #(.COUNT_DIV(2), .EXC_VECTOR(32'hBFC0_0380)) dut (
        .clk(clk), .rst(rst), .RAddr(RAddr), .RData(RData),
        .WE(WE), .WBWAddr(WBWAddr), .WData(WData), .HwInt(HwInt),
        .ExcValid(ExcValid), .ExcCode(ExcCode), .ExcPC(ExcPC), .ExcBD(ExcBD),
        .ExcBadVA(ExcBadVA), .Eret(Eret), .EPCOut(EPCOut),
        .ExcTarget(ExcTarget), .IntReq(IntReq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        bd;
        logic [31:0] badva;
        logic        eret;
        logic [4:0]  raddr;
        logic [31:0] exp_rdata;
        logic        exp_intreq;
        logic [31:0] exp_epc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                                input logic exc, input logic [4:0] code, input logic [31:0] pc,
                                input logic bd, input logic [31:0] badva, input logic eret,
                                input logic [4:0] raddr, input logic [31:0] exp_rdata,
                                input logic exp_intreq, input logic [31:0] exp_epc);
        vec_t v;
        v.we = we; v.waddr = waddr; v.wdata = wdata;
        v.exc = exc; v.code = code; v.pc = pc; v.bd = bd; v.badva = badva;
        v.eret = eret; v.raddr = raddr;
        v.exp_rdata = exp_rdata; v.exp_intreq = exp_intreq; v.exp_epc = exp_epc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        RAddr = a;
        #1;
        d = RData;
    endtask

    task automatic idle(input int n);
        WE = 1'b0; ExcValid = 1'b0; Eret = 1'b0;
        repeat (n) tick();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        WE = 1'b1; WBWAddr = a; WData = d;
        ExcValid = 1'b0; Eret = 1'b0;
        tick();
        WE = 1'b0;
    endtask

    logic [31:0] r;

    initial begin
        rst = 1'b1;
        RAddr = 5'd0; WE = 1'b0; WBWAddr = 5'd0; WData = 32'h0; HwInt = 6'h0;
        ExcValid = 1'b0; ExcCode = 5'd0; ExcPC = 32'h0; ExcBD = 1'b0;
        ExcBadVA = 32'h0; Eret = 1'b0;

        //        we  waddr  wdata         exc code pc            bd badva        eret raddr exp_rdata     irq epc
        vq.push_back(mk(1, 5'd12, 32'h0000_FF03, 0, 5'd0, 32'h0,        0, 32'h0,      0, 5'd12, 32'h0000_FF03, 0, 32'h0));
        vq.push_back(mk(1, 5'd12, 32'hFFFF_FFFF, 0, 5'd0, 32'h0,        0, 32'h0,      0, 5'd12, 32'h0000_FF03, 0, 32'h0));
        vq.push_back(mk(1, 5'd13, 32'hFFFF_FFFF, 0, 5'd0, 32'h0,        0, 32'h0,      0, 5'd13, 32'h0000_0300, 0, 32'h0));
        vq.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,        0, 32'h0,      0, 5'd13, 32'h0000_0300, 0, 32'h0));
        vq.push_back(mk(1, 5'd12, 32'h0000_0301, 0, 5'd0, 32'h0,        0, 32'h0,      0, 5'd12, 32'h0000_0301, 0, 32'h0));
        vq.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,        0, 32'h0,      0, 5'd12, 32'h0000_0301, 1, 32'h0));
        vq.push_back(mk(1, 5'd13, 32'h0,         0, 5'd0, 32'h0,        0, 32'h0,      0, 5'd13, 32'h0,         1, 32'h0));
        vq.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,        0, 32'h0,      0, 5'd13, 32'h0,         0, 32'h0));
        vq.push_back(mk(0, 5'd0,  32'h0,         1, 5'd4, 32'h0040_0100, 1, 32'h13,    0, 5'd13, 32'h8000_0010, 0, 32'h0040_00FC));
        vq.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,        0, 32'h0,      0, 5'd14, 32'h0040_00FC, 0, 32'h0040_00FC));
        vq.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,        0, 32'h0,      0, 5'd8,  32'h13,        0, 32'h0040_00FC));
        vq.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,        0, 32'h0,      0, 5'd12, 32'h0000_0303, 0, 32'h0040_00FC));
        vq.push_back(mk(0, 5'd0,  32'h0,         1, 5'd8, 32'h0050_0000, 0, 32'hDEAD,  0, 5'd14, 32'h0040_00FC, 0, 32'h0040_00FC));
        vq.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,        0, 32'h0,      0, 5'd13, 32'h8000_0020, 0, 32'h0040_00FC));
        vq.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,        0, 32'h0,      0, 5'd8,  32'h13,        0, 32'h0040_00FC));
        vq.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,        0, 32'h0,      1, 5'd12, 32'h0000_0301, 0, 32'h0040_00FC));
        vq.push_back(mk(1, 5'd12, 32'h0,         1, 5'd0, 32'h0060_0000, 0, 32'h0,     1, 5'd12, 32'h0000_0303, 0, 32'h0060_0000));
        vq.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,        0, 32'h0,      0, 5'd14, 32'h0060_0000, 0, 32'h0060_0000));
        vq.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,        0, 32'h0,      0, 5'd13, 32'h0,         0, 32'h0060_0000));
        vq.push_back(mk(1, 5'd12, 32'h0000_FF03, 0, 5'd0, 32'h0,        0, 32'h0,      1, 5'd12, 32'h0000_FF01, 0, 32'h0060_0000));
        vq.push_back(mk(1, 5'd14, 32'h1234,      1, 5'd5, 32'h0070_0008, 0, 32'hABCD,  0, 5'd14, 32'h0070_0008, 0, 32'h0070_0008));
        vq.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,        0, 32'h0,      0, 5'd8,  32'hABCD,      0, 32'h0070_0008));
        vq.push_back(mk(1, 5'd14, 32'h1234,      0, 5'd0, 32'h0,        0, 32'h0,      0, 5'd14, 32'h1234,      0, 32'h1234));
        vq.push_back(mk(1, 5'd10, 32'hFFFF,      0, 5'd0, 32'h0,        0, 32'h0,      0, 5'd10, 32'h0,         0, 32'h1234));
        vq.push_back(mk(1, 5'd8,  32'hFFFF_FFFF, 0, 5'd0, 32'h0,        0, 32'h0,      0, 5'd8,  32'hABCD,      0, 32'h1234));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rd(5'd12, r); chk("reset status", r, 32'h2);
        rd(5'd13, r); chk("reset cause", r, 32'h0);
        rd(5'd9, r);  chk("reset count", r, 32'h0);
        chk("reset epc", EPCOut, 32'h0);
        chk("reset intreq", {31'h0, IntReq}, 32'h0);
        chk("exc target", ExcTarget, 32'hBFC0_0380);
        rst = 1'b0;

        // Table-driven single-cycle vectors
        for (int i = 0; i < vq.size(); i++) begin
            WE = vq[i].we; WBWAddr = vq[i].waddr; WData = vq[i].wdata;
            ExcValid = vq[i].exc; ExcCode = vq[i].code; ExcPC = vq[i].pc;
            ExcBD = vq[i].bd; ExcBadVA = vq[i].badva; Eret = vq[i].eret;
            RAddr = vq[i].raddr;
            tick();
            chk($sformatf("vec%0d rdata", i), RData, vq[i].exp_rdata);
            chk($sformatf("vec%0d intreq", i), {31'h0, IntReq}, {31'h0, vq[i].exp_intreq});
            chk($sformatf("vec%0d epc", i), EPCOut, vq[i].exp_epc);
        end
        idle(0);
        ExcBD = 1'b0; ExcCode = 5'd0; ExcPC = 32'h0; ExcBadVA = 32'h0;

        // Timer: Count reaches Compare after 20 cycles, IP7 one cycle later
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd10);
        idle(18);
        rd(5'd9, r);  chk("timer count@19", r, 32'd9);
        rd(5'd13, r); chk("timer ip7@19", {31'h0, r[15]}, 32'h0);
        idle(1);
        rd(5'd9, r);  chk("timer count@20", r, 32'd10);
        rd(5'd13, r); chk("timer ip7@20", {31'h0, r[15]}, 32'h0);
        idle(1);
        rd(5'd13, r); chk("timer ip7@21", {31'h0, r[15]}, 32'h1);
        chk("timer intreq@21", {31'h0, IntReq}, 32'h0);
        idle(1);
        chk("timer intreq@22", {31'h0, IntReq}, 32'h1);
        mtc0(5'd11, 32'd10);
        rd(5'd13, r); chk("timer ip7 cleared", {31'h0, r[15]}, 32'h0);
        chk("timer intreq lag", {31'h0, IntReq}, 32'h1);
        idle(1);
        chk("timer intreq off", {31'h0, IntReq}, 32'h0);

        // Count load on an increment edge wins and restarts the divider
        mtc0(5'd11, 32'h0);
        mtc0(5'd9, 32'd100);
        idle(1);
        rd(5'd9, r); chk("count hold 100", r, 32'd100);
        mtc0(5'd9, 32'd5);
        rd(5'd9, r); chk("count load 5", r, 32'd5);
        idle(1);
        rd(5'd9, r); chk("count div restart", r, 32'd5);
        idle(1);
        rd(5'd9, r); chk("count inc 6", r, 32'd6);

        // Hardware interrupt path
        mtc0(5'd12, 32'h0000_0401);
        idle(1);
        chk("hw intreq idle", {31'h0, IntReq}, 32'h0);
        HwInt = 6'b000001;
        tick();
        rd(5'd13, r); chk("hw ip2 set", {31'h0, r[10]}, 32'h1);
        chk("hw intreq +1", {31'h0, IntReq}, 32'h0);
        tick();
        chk("hw intreq +2", {31'h0, IntReq}, 32'h1);
        HwInt = 6'b000000;
        tick();
        rd(5'd13, r); chk("hw ip2 clr", {31'h0, r[10]}, 32'h0);
        chk("hw intreq drop+1", {31'h0, IntReq}, 32'h1);
        tick();
        chk("hw intreq drop+2", {31'h0, IntReq}, 32'h0);

        // Asynchronous reset mid-operation
        HwInt = 6'b000001;
        tick();
        tick();
        chk("pre-reset intreq", {31'h0, IntReq}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("async rst intreq", {31'h0, IntReq}, 32'h0);
        chk("async rst epc", EPCOut, 32'h0);
        rd(5'd12, r); chk("async rst status", r, 32'h2);
        rd(5'd9, r);  chk("async rst count", r, 32'h0);
        HwInt = 6'b000000;
        tick();
        rst = 1'b0;
        tick();
        rd(5'd12, r); chk("post-reset status", r, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
